// File: rtl/hazard_unit.sv
// Pipeline hazard/control unit: stage enables, flushes, PC select, D-cache wait and halt FSM.
// Optional HAZARD_FWD_EN enables forwarding selects; otherwise RAW hazards stall.
module hazard_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             ex_WrDest,
    input  logic                   ex_RegWr,
    input  logic                   ex_MemtoReg,
    input  logic [4:0]             mem_WrDest,
    input  logic                   mem_RegWr,
    input  logic                   mem_MemRd,
    input  logic                   mem_MemWr,
    input  logic                   mem_beq,
    input  logic                   mem_bne,
    input  logic                   mem_zero,
    input  logic                   mem_jump,
    input  logic                   mem_jreg,
    input  logic                   wb_Halt,
    output logic                   pc_en,
    output logic [1:0]             pc_sel,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

    state_t state, next_state;
    logic   count_evt;
    logic   freeze;
    logic   memop, taken, load_use, raw_stall;
    logic   ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic [1:0] fwd_rs, fwd_rt;

    // Producers with destination $0 never create a hazard.
    assign ex_hit_rs  = ex_RegWr  && (ex_WrDest  != '0) && (ex_WrDest  == id_rs);
    assign ex_hit_rt  = ex_RegWr  && (ex_WrDest  != '0) && (ex_WrDest  == id_rt);
    assign mem_hit_rs = mem_RegWr && (mem_WrDest != '0) && (mem_WrDest == id_rs);
    assign mem_hit_rt = mem_RegWr && (mem_WrDest != '0) && (mem_WrDest == id_rt);

    assign memop    = mem_MemRd | mem_MemWr;
    assign taken    = (mem_beq & mem_zero) | (mem_bne & ~mem_zero) | mem_jump | mem_jreg;
    assign load_use = ex_MemtoReg & (ex_hit_rs | ex_hit_rt);

`ifdef HAZARD_FWD_EN
    // EX/MEM producer (MEM stage) wins; the EX-stage producer supplies the MEM/WB path.
    assign fwd_rs    = mem_hit_rs ? 2'd1 : (ex_hit_rs ? 2'd2 : 2'd0);
    assign fwd_rt    = mem_hit_rt ? 2'd1 : (ex_hit_rt ? 2'd2 : 2'd0);
    assign raw_stall = load_use;
`else
    assign fwd_rs    = 2'd0;
    assign fwd_rt    = 2'd0;
    assign raw_stall = load_use | ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt;
`endif

    always_comb begin
        next_state  = state;
        count_evt   = 1'b0;
        freeze      = 1'b0;
        pc_en       = 1'b1;
        pc_sel      = 2'd0;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        fwd_a       = fwd_rs;
        fwd_b       = fwd_rt;

        if (!nRST) begin
            freeze     = 1'b1;
            fwd_a      = 2'd0;
            fwd_b      = 2'd0;
            next_state = RUN;
        end else if (state == HALTED) begin
            freeze = 1'b1;
        end else if (state == RUN && wb_Halt) begin
            freeze     = 1'b1;
            next_state = HALTED;
        end else if (memop && !dhit) begin
            freeze     = 1'b1;
            count_evt  = 1'b1;
            next_state = DWAIT;
        end else begin
            next_state = RUN;
            if (taken) begin
                pc_sel      = mem_jreg ? 2'd3 : (mem_jump ? 2'd2 : 2'd1);
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (raw_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                count_evt  = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                count_evt  = 1'b1;
            end
        end

        if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            halt  <= (next_state == HALTED);
            if (count_evt && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule
